mc_main_ctrl: RTL and testbench

Multicycle main control FSM for the MIPS datapath, replacing the fixed-latency decoder. It sequences fetch, decode, execute, memory and writeback per opcode, as before. It adds a `mem_req`/`mem_ready` wait-state handshake on every memory-accessing state and gates 64-bit opcodes by the `XLEN` parameter. It also adds an optional trap path for illegal opcodes and memory timeouts. It drives all datapath control strobes and exposes its state code for debug.

---
 rtl/mc_main_ctrl_if.sv | 12 +
 rtl/mc_main_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_main_ctrl_if.sv
// Memory-port bundle between the main control FSM (master) and the memory
// (slave): request/ready handshake plus address-select and access type.
interface mc_main_ctrl_if;
    logic       mem_req;
    logic       mem_ready;
    logic       iord;
    logic [1:0] memwrite;
    logic [2:0] readtype;

    modport master (output mem_req, iord, memwrite, readtype, input mem_ready);
    modport slave  (input mem_req, iord, memwrite, readtype, output mem_ready);
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM with mem_req/mem_ready wait states and XLEN-gated 64-bit ops.
// Define MC_MAIN_CTRL_TRAP_EN to add the TRAP state, memory timeout counter and cause register.
module mc_main_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [5:0]     op,
    mc_main_ctrl_if.master mem,
    output logic           pcwrite,
    output logic           irwrite,
    output logic           regwrite,
    output logic           branch,
    output logic           bne,
    output logic           memtoreg,
    output logic           regdst,
    output logic           alusrca,
    output logic [2:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [2:0]     aluop,
    output logic           epcwrite,
    output logic [1:0]     cause,
    output logic [4:0]     state_o
);

    typedef enum logic [4:0] {
        S_IF       = 5'd0,  S_ID       = 5'd1,  S_EX_LS    = 5'd2,  S_MEM_LD   = 5'd3,
        S_MEM_LWU  = 5'd4,  S_MEM_LW   = 5'd5,  S_MEM_LBU  = 5'd6,  S_MEM_LB   = 5'd7,
        S_WB_L     = 5'd8,  S_MEM_SD   = 5'd9,  S_MEM_SW   = 5'd10, S_MEM_SB   = 5'd11,
        S_EX_RTYPE = 5'd12, S_WB_RTYPE = 5'd13, S_EX_BEQ   = 5'd14, S_EX_BNE   = 5'd15,
        S_EX_J     = 5'd16, S_EX_ADDI  = 5'd17, S_EX_ANDI  = 5'd18, S_EX_ORI   = 5'd19,
        S_EX_SLTI  = 5'd20, S_EX_DADDI = 5'd21, S_WB_I     = 5'd22, S_TRAP     = 5'd23
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LD   = 6'b110111, OP_LWU  = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_LBU  = 6'b100100, OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b111111, OP_SW   = 6'b101011, OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_DADDI = 6'b011000;
    localparam bit         HAS64    = (XLEN == 64);

    state_e state_q, state_d;
    logic   mem_req;

`ifdef MC_MAIN_CTRL_TRAP_EN
    localparam state_e     ILL_NEXT = S_TRAP;
    localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

    logic [7:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    logic       timeout;

    // The limit cycle only traps if memory is still not ready in it.
    assign timeout = mem_req && !mem.mem_ready && (wait_q == WAIT_LIM);

    always_comb begin
        wait_d  = wait_q;
        cause_d = cause_q;
        if (state_d != state_q)             wait_d = '0;
        else if (mem_req && !mem.mem_ready) wait_d = wait_q + 8'd1;
        if (state_d == S_TRAP && state_q != S_TRAP) cause_d = timeout ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q  <= '0;
            cause_q <= '0;
        end else begin
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    assign cause = cause_q;
`else
    localparam state_e ILL_NEXT = S_IF;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    assign cause = 2'b00;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            S_IF: if (mem.mem_ready) state_d = S_ID;
            S_ID: begin
                state_d = ILL_NEXT;
                case (op)
                    OP_LW, OP_LWU, OP_LB, OP_LBU, OP_SW, OP_SB: state_d = S_EX_LS;
                    OP_LD, OP_SD: if (HAS64) state_d = S_EX_LS;
                    OP_RTYPE: state_d = S_EX_RTYPE;
                    OP_BEQ:   state_d = S_EX_BEQ;
                    OP_BNE:   state_d = S_EX_BNE;
                    OP_J:     state_d = S_EX_J;
                    OP_ADDI:  state_d = S_EX_ADDI;
                    OP_ANDI:  state_d = S_EX_ANDI;
                    OP_ORI:   state_d = S_EX_ORI;
                    OP_SLTI:  state_d = S_EX_SLTI;
                    OP_DADDI: if (HAS64) state_d = S_EX_DADDI;
                    default: ;
                endcase
            end
            S_EX_LS: begin
                case (op)
                    OP_LD:   state_d = S_MEM_LD;
                    OP_LWU:  state_d = S_MEM_LWU;
                    OP_LW:   state_d = S_MEM_LW;
                    OP_LBU:  state_d = S_MEM_LBU;
                    OP_LB:   state_d = S_MEM_LB;
                    OP_SD:   state_d = S_MEM_SD;
                    OP_SW:   state_d = S_MEM_SW;
                    OP_SB:   state_d = S_MEM_SB;
                    default: state_d = S_IF;
                endcase
            end
            S_MEM_LD, S_MEM_LWU, S_MEM_LW, S_MEM_LBU, S_MEM_LB:
                if (mem.mem_ready) state_d = S_WB_L;
            S_MEM_SD, S_MEM_SW, S_MEM_SB:
                if (mem.mem_ready) state_d = S_IF;
            S_EX_RTYPE: state_d = S_WB_RTYPE;
            S_EX_ADDI, S_EX_ANDI, S_EX_ORI, S_EX_SLTI, S_EX_DADDI: state_d = S_WB_I;
            default: state_d = S_IF;
        endcase
`ifdef MC_MAIN_CTRL_TRAP_EN
        if (timeout) state_d = S_TRAP;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        mem_req      = 1'b0;
        mem.iord     = 1'b0;
        mem.memwrite = 2'b00;
        mem.readtype = 3'b000;
        pcwrite      = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        branch       = 1'b0;
        bne          = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 3'b000;
        pcsrc        = 2'b00;
        aluop        = 3'b000;
        epcwrite     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = 3'b001;
                irwrite = mem.mem_ready;
                pcwrite = mem.mem_ready;
            end
            S_ID:    alusrcb = 3'b011;
            S_EX_LS: begin alusrca = 1'b1; alusrcb = 3'b010; end
            S_MEM_LD:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.readtype = 3'b100; end
            S_MEM_LWU: begin mem_req = 1'b1; mem.iord = 1'b1; mem.readtype = 3'b001; end
            S_MEM_LW:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.readtype = 3'b000; end
            S_MEM_LBU: begin mem_req = 1'b1; mem.iord = 1'b1; mem.readtype = 3'b011; end
            S_MEM_LB:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.readtype = 3'b010; end
            S_WB_L:    begin regwrite = 1'b1; memtoreg = 1'b1; end
            S_MEM_SD:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.memwrite = 2'b11; end
            S_MEM_SW:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.memwrite = 2'b01; end
            S_MEM_SB:  begin mem_req = 1'b1; mem.iord = 1'b1; mem.memwrite = 2'b10; end
            S_EX_RTYPE: begin alusrca = 1'b1; aluop = 3'b010; end
            S_WB_RTYPE: begin regwrite = 1'b1; regdst = 1'b1; end
            S_EX_BEQ:  begin alusrca = 1'b1; branch = 1'b1; pcsrc = 2'b01; aluop = 3'b001; end
            S_EX_BNE:  begin alusrca = 1'b1; bne = 1'b1; pcsrc = 2'b01; aluop = 3'b001; end
            S_EX_J:    begin pcwrite = 1'b1; pcsrc = 2'b10; end
            S_EX_ADDI:  begin alusrca = 1'b1; alusrcb = 3'b010; aluop = 3'b000; end
            S_EX_ANDI:  begin alusrca = 1'b1; alusrcb = 3'b011; aluop = 3'b100; end
            S_EX_ORI:   begin alusrca = 1'b1; alusrcb = 3'b100; aluop = 3'b100; end
            S_EX_SLTI:  begin alusrca = 1'b1; alusrcb = 3'b101; aluop = 3'b010; end
            S_EX_DADDI: begin alusrca = 1'b1; alusrcb = 3'b110; aluop = 3'b010; end
            S_WB_I:     regwrite = 1'b1;
`ifdef MC_MAIN_CTRL_TRAP_EN
            S_TRAP:     begin pcwrite = 1'b1; epcwrite = 1'b1; pcsrc = 2'b11; end
`endif
            default: ;
        endcase
    end

    assign mem.mem_req = mem_req;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: instructions expand to phase lists, the expected
// per-cycle outputs are queued, and a negedge monitor compares them with the DUT.
module tb_mc_main_ctrl;

    typedef struct packed {
        logic [4:0] state;
        logic       mem_req, pcwrite, irwrite, regwrite, branch, bne, iord, memtoreg, regdst, alusrca;
        logic [1:0] memwrite;
        logic [2:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic [2:0] readtype;
        logic       epcwrite;
        logic [1:0] cause;
    } obs_t;

    // Phases an instruction walks through after ID (n = 0 means illegal).
    typedef struct packed {
        logic [1:0] n;
        logic [4:0] p0, p1, p2;
    } ins_t;

`ifdef MC_MAIN_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_SB = 6'b101000;
    localparam logic [5:0] OP_LD = 6'b110111, OP_SD = 6'b111111, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J  = 6'b000010, OP_DADDI = 6'b011000, OP_BAD = 6'b111000;

    logic       clk = 1'b0;
    logic       rst_a [2];
    logic [5:0] op_a  [2];
    logic       rdy_a [2];
    obs_t       obs   [2];

    always #5 clk = ~clk;

    // Instance 0: XLEN=64, TIMEOUT=16. Instance 1: XLEN=32, TIMEOUT=4.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_main_ctrl_if bus ();
        logic       pcwrite, irwrite, regwrite, branch, bne, memtoreg, regdst, alusrca, epcwrite;
        logic [2:0] alusrcb, aluop;
        logic [1:0] pcsrc, cause;
        logic [4:0] state;

        assign bus.mem_ready = rdy_a[g];

        mc_main_ctrl #(.XLEN(g == 0 ? 64 : 32), .TIMEOUT(g == 0 ? 16 : 4)) dut (
            .clk      (clk),
            .reset    (rst_a[g]),
            .op       (op_a[g]),
            .mem      (bus),
            .pcwrite  (pcwrite),
            .irwrite  (irwrite),
            .regwrite (regwrite),
            .branch   (branch),
            .bne      (bne),
            .memtoreg (memtoreg),
            .regdst   (regdst),
            .alusrca  (alusrca),
            .alusrcb  (alusrcb),
            .pcsrc    (pcsrc),
            .aluop    (aluop),
            .epcwrite (epcwrite),
            .cause    (cause),
            .state_o  (state)
        );

        assign obs[g] = {state, bus.mem_req, pcwrite, irwrite, regwrite, branch, bne, bus.iord,
                         memtoreg, regdst, alusrca, bus.memwrite, alusrcb, pcsrc, aluop,
                         bus.readtype, epcwrite, cause};
    end

    int         n_checks = 0;
    int         n_errors = 0;
    obs_t       exp_q [$];
    int         active = 0;
    int         cur_xlen = 64;
    int         cur_timeout = 16;
    logic [1:0] cause_m = 2'b00;

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs of one cycle spent in state st with mem_ready = rdy.
    function automatic obs_t exp_out(input logic [4:0] st, input logic rdy);
        obs_t o;
        o       = '0;
        o.state = st;
        o.cause = cause_m;
        case (st)
            5'd0:  begin o.mem_req = 1; o.alusrcb = 3'b001; o.irwrite = rdy; o.pcwrite = rdy; end
            5'd1:  o.alusrcb = 3'b011;
            5'd2:  begin o.alusrca = 1; o.alusrcb = 3'b010; end
            5'd3:  begin o.mem_req = 1; o.iord = 1; o.readtype = 3'b100; end
            5'd4:  begin o.mem_req = 1; o.iord = 1; o.readtype = 3'b001; end
            5'd5:  begin o.mem_req = 1; o.iord = 1; o.readtype = 3'b000; end
            5'd6:  begin o.mem_req = 1; o.iord = 1; o.readtype = 3'b011; end
            5'd7:  begin o.mem_req = 1; o.iord = 1; o.readtype = 3'b010; end
            5'd8:  begin o.regwrite = 1; o.memtoreg = 1; end
            5'd9:  begin o.mem_req = 1; o.iord = 1; o.memwrite = 2'b11; end
            5'd10: begin o.mem_req = 1; o.iord = 1; o.memwrite = 2'b01; end
            5'd11: begin o.mem_req = 1; o.iord = 1; o.memwrite = 2'b10; end
            5'd12: begin o.alusrca = 1; o.aluop = 3'b010; end
            5'd13: begin o.regwrite = 1; o.regdst = 1; end
            5'd14: begin o.alusrca = 1; o.branch = 1; o.pcsrc = 2'b01; o.aluop = 3'b001; end
            5'd15: begin o.alusrca = 1; o.bne = 1; o.pcsrc = 2'b01; o.aluop = 3'b001; end
            5'd16: begin o.pcwrite = 1; o.pcsrc = 2'b10; end
            5'd17: begin o.alusrca = 1; o.alusrcb = 3'b010; o.aluop = 3'b000; end
            5'd18: begin o.alusrca = 1; o.alusrcb = 3'b011; o.aluop = 3'b100; end
            5'd19: begin o.alusrca = 1; o.alusrcb = 3'b100; o.aluop = 3'b100; end
            5'd20: begin o.alusrca = 1; o.alusrcb = 3'b101; o.aluop = 3'b010; end
            5'd21: begin o.alusrca = 1; o.alusrcb = 3'b110; o.aluop = 3'b010; end
            5'd22: o.regwrite = 1;
            5'd23: begin o.pcwrite = 1; o.epcwrite = 1; o.pcsrc = 2'b11; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic ins_t mk(input int n, input int a, input int b, input int c);
        ins_t d;
        d.n  = 2'(n);
        d.p0 = 5'(a);
        d.p1 = 5'(b);
        d.p2 = 5'(c);
        return d;
    endfunction

    function automatic ins_t lookup(input logic [5:0] op, input int xlen);
        bit w = (xlen == 64);
        case (op)
            6'b000000: return mk(2, 12, 13, 0);
            6'b110111: return w ? mk(3, 2, 3, 8) : mk(0, 0, 0, 0);
            6'b100111: return mk(3, 2, 4, 8);
            6'b100011: return mk(3, 2, 5, 8);
            6'b100100: return mk(3, 2, 6, 8);
            6'b100000: return mk(3, 2, 7, 8);
            6'b111111: return w ? mk(2, 2, 9, 0) : mk(0, 0, 0, 0);
            6'b101011: return mk(2, 2, 10, 0);
            6'b101000: return mk(2, 2, 11, 0);
            6'b000100: return mk(1, 14, 0, 0);
            6'b000101: return mk(1, 15, 0, 0);
            6'b000010: return mk(1, 16, 0, 0);
            6'b001000: return mk(2, 17, 22, 0);
            6'b001100: return mk(2, 18, 22, 0);
            6'b001101: return mk(2, 19, 22, 0);
            6'b001010: return mk(2, 20, 22, 0);
            6'b011000: return w ? mk(2, 21, 22, 0) : mk(0, 0, 0, 0);
            default:   return mk(0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic [5:0] op_at(input int i);
        case (i)
            0: return 6'b000000;  1: return 6'b110111;  2: return 6'b100111;  3: return 6'b100011;
            4: return 6'b100100;  5: return 6'b100000;  6: return 6'b111111;  7: return 6'b101011;
            8: return 6'b101000;  9: return 6'b000100; 10: return 6'b000101; 11: return 6'b000010;
            12: return 6'b001000; 13: return 6'b001100; 14: return 6'b001101; 15: return 6'b001010;
            default: return 6'b011000;
        endcase
    endfunction

    function automatic bit is_mem(input logic [4:0] st);
        return (st >= 5'd3 && st <= 5'd7) || (st >= 5'd9 && st <= 5'd11);
    endfunction

    // Drive one cycle and queue what the DUT must show during it.
    task automatic drive_cycle(input logic [5:0] op, input logic rdy, input logic [4:0] st);
        op_a[active]  = op;
        rdy_a[active] = rdy;
        exp_q.push_back(exp_out(st, rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input logic [5:0] op, input logic [4:0] st, input int w,
                             output bit trapped);
        bit expire = TRAP_EN && (w >= cur_timeout);
        int nw     = expire ? cur_timeout : w;
        for (int i = 0; i < nw; i++) drive_cycle(op, 1'b0, st);
        trapped = expire;
        if (!expire) drive_cycle(op, 1'b1, st);
    endtask

    task automatic trap_cycle(input logic [5:0] op, input logic [1:0] c);
        cause_m = c;
        drive_cycle(op, 1'($urandom_range(0, 1)), 5'd23);
    endtask

    task automatic run_instr(input logic [5:0] op, input int w_if, input int w_mem);
        ins_t d = lookup(op, cur_xlen);
        bit   trapped;
        logic [4:0] st;
        mem_phase(op, 5'd0, w_if, trapped);
        if (trapped) begin
            trap_cycle(op, 2'b10);
            return;
        end
        drive_cycle(op, 1'($urandom_range(0, 1)), 5'd1);
        if (d.n == 0) begin
            if (TRAP_EN) trap_cycle(op, 2'b01);
            return;
        end
        for (int i = 0; i < int'(d.n); i++) begin
            st = (i == 0) ? d.p0 : (i == 1) ? d.p1 : d.p2;
            if (is_mem(st)) begin
                mem_phase(op, st, w_mem, trapped);
                if (trapped) begin
                    trap_cycle(op, 2'b10);
                    return;
                end
            end else begin
                drive_cycle(op, 1'($urandom_range(0, 1)), st);
            end
        end
    endtask

    task automatic random_block(input int n);
        for (int k = 0; k < n; k++) begin
            logic [5:0] o;
            int wi, wm;
            o  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_at(int'($urandom_range(0, 16)));
            wi = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_instr(o, wi, wm);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check($sformatf("dut%0d state%0d", active, e.state), obs[active], e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        op_a[0]  = '0;   op_a[1]  = '0;
        rdy_a[0] = 1'b0; rdy_a[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_cycle(6'd0, 1'b1, 5'd0);
        rst_a[0] = 1'b0;

        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_LD, 0, 0);
        run_instr(OP_SD, 2, 1);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_BAD, 0, 0);
        run_instr(OP_DADDI, 1, 0);
        random_block(150);

        rst_a[0]    = 1'b1;
        active      = 1;
        cur_xlen    = 32;
        cur_timeout = 4;
        cause_m     = 2'b00;
        rst_a[1]    = 1'b0;

        run_instr(OP_LD, 0, 0);
        run_instr(OP_LW, 4, 0);
        run_instr(OP_LW, 3, 0);
        run_instr(OP_SD, 0, 0);
        run_instr(OP_LW, 0, 4);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_DADDI, 0, 0);
        random_block(150);

        // Abort an SB access mid-wait with an asynchronous reset.
        run_instr(OP_BAD, 0, 0);
        drive_cycle(OP_SB, 1'b1, 5'd0);
        drive_cycle(OP_SB, 1'b0, 5'd1);
        drive_cycle(OP_SB, 1'b1, 5'd2);
        drive_cycle(OP_SB, 1'b0, 5'd11);
        rdy_a[1] = 1'b0;
        @(negedge clk);
        #1;
        rst_a[1] = 1'b1;
        #1;
        o = obs[1];
        check("reset_abort", 31'({o.state, o.memwrite, o.regwrite, o.pcwrite, o.epcwrite, o.cause}), 31'd0);
        @(posedge clk);
        #1;
        cause_m  = 2'b00;
        rst_a[1] = 1'b0;
        run_instr(OP_LW, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", 31'(exp_q.size()), 31'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
